// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: bundles the operand input handshake, the divider-side
// start/status/result signals, the result output handshake and the FIFO level
// of div_issue_ctrl.
// slave  - the view taken by div_issue_ctrl itself.
// master - the view taken by the environment around it (source, divider, sink).
interface div_issue_ctrl_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    // operand input handshake
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    // downstream divider
    logic             div_start;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_busy;
    logic             div_valid;
    logic [WIDTH-1:0] div_q;
    logic             div_ov;

    // result output handshake
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic             out_ov;

    // FIFO occupancy
    logic [LW-1:0]    level;

    modport slave (
        input  in_valid, in_a, in_b,
        input  div_busy, div_valid, div_q, div_ov,
        input  out_ready,
        output in_ready, div_start, div_a, div_b,
        output out_valid, out_q, out_ov, level
    );

    modport master (
        output in_valid, in_a, in_b,
        output div_busy, div_valid, div_q, div_ov,
        output out_ready,
        input  in_ready, div_start, div_a, div_b,
        input  out_valid, out_q, out_ov, level
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: buffers operand pairs in a small FIFO and issues them one
// at a time to a multi-cycle divider, then returns each quotient over a
// valid/ready handshake.
// Optional build macro: DIV_ZERO_BYPASS_EN -- when defined, a pair with a zero
// divisor never reaches the divider; it is answered directly with an all-ones
// quotient and the overflow flag set.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on FIFO fullness (a pop in the same cycle does
// not make room). out_valid, once raised, stays high with out_q/out_ov stable
// until the edge where out_ready is 1.
// dbg_state exposes the FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 HOLD.
module div_issue_ctrl #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4     // power of two, 2 or more
) (
    input  logic             clk,
    input  logic             rst,        // synchronous, active low
    div_issue_ctrl_if.slave  bus,
    output logic [1:0]       dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [LW-1:0]      level_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               capture;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   div_a_q;
    logic [WIDTH-1:0]   div_b_q;
    logic [WIDTH-1:0]   out_q_q;
    logic               out_ov_q;
`ifdef DIV_ZERO_BYPASS_EN
    logic               bypass;
`endif

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = bus.in_valid && !full;
    assign head  = mem[rd_ptr];   // {dividend, divisor}

    assign bus.in_ready  = !full;
    assign bus.level     = level_q;
    assign bus.div_start = (state == ISSUE);
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_q     = out_q_q;
    assign bus.out_ov    = out_ov_q;
    assign dbg_state     = state;

    // FSM state register; reset abandons any in-flight pair
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state plus pop/capture strobes; div_valid only matters in WAIT
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        bypass    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty && !bus.div_busy) begin
                    pop = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                    if (head[WIDTH-1:0] == '0) begin
                        bypass    = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = ISSUE;
                    end
`else
                    state_nxt = ISSUE;
`endif
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.div_valid) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because the pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_a, bus.in_b};
        end
    end

    // FIFO pointers wrap naturally at DEPTH; level saturates by construction
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // operand hold registers and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_a_q  <= '0;
            div_b_q  <= '0;
            out_q_q  <= '0;
            out_ov_q <= 1'b0;
        end else begin
            if (pop) begin
                div_a_q <= head[2*WIDTH-1:WIDTH];
                div_b_q <= head[WIDTH-1:0];
            end
            if (capture) begin
                out_q_q  <= bus.div_q;
                out_ov_q <= bus.div_ov;
            end
`ifdef DIV_ZERO_BYPASS_EN
            if (bypass) begin
                out_q_q  <= '1;
                out_ov_q <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: bench for div_issue_ctrl with a behavioural divider,
// an in-order result scoreboard, a vector table and directed corner cases.
module tb_div_issue_ctrl;
    localparam int W  = 10;
    localparam int D  = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd2;
`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic         ov;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // environment controls
    bit force_busy = 1'b0;
    bit hang       = 1'b0;
    bit stray_on   = 1'b0;
    bit rdy_mode   = 1'b0;
    bit rdy_val    = 1'b1;

    // divider model state
    bit           m_busy  = 1'b0;
    bit           m_valid = 1'b0;
    int           m_cnt   = 0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    logic [W-1:0] m_q     = '0;
    logic         m_ov    = 1'b0;

    // scoreboard: {ov, q} expected in push order
    logic [W:0] exp_q[$];
    logic [W:0] sb_e;
    int start_cnt = 0;
    int push_cnt  = 0;
    int nz_push   = 0;

    div_issue_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

    div_issue_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required end before time limit");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endfunction

    // reference result of a pair: plain integer division, divisor 0 saturates
    function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {1'b1, {W{1'b1}}};
        return {1'b0, W'(a / b)};
    endfunction

    // result sink ready
    always @(posedge clk) begin
        #2;
        bus.out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    // divider model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
            exp_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_result(bus.in_a, bus.in_b));
                push_cnt++;
                if (bus.in_b != '0) nz_push++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_has_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    check("sb_result", {bus.out_ov, bus.out_q}, sb_e);
                end
            end
            if (bus.div_start) start_cnt++;
            if (m_valid) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end else if (m_busy) begin
                if (!hang) begin
                    if (m_cnt == 0) begin
                        check("div_a_stable", bus.div_a, m_a);
                        check("div_b_stable", bus.div_b, m_b);
                        m_valid = 1'b1;
                        m_q     = (m_b == '0) ? '1 : W'(m_a / m_b);
                        m_ov    = (m_b == '0);
                    end else begin
                        m_cnt--;
                    end
                end
            end else if (bus.div_start) begin
                m_busy = 1'b1;
                m_a    = bus.div_a;
                m_b    = bus.div_b;
                m_cnt  = $urandom_range(0, 3);
            end
        end
        bus.div_busy  = m_busy || force_busy;
        bus.div_valid = m_valid || stray_on;
        bus.div_q     = stray_on ? W'(341) : m_q;
        bus.div_ov    = stray_on ? 1'b1 : m_ov;
    end

    // driver tasks: all start and end at posedge+1
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 1'b0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        bus.in_valid = 1'b0;
        check("offer_accepted", ok, 1);
    endtask

    // returns at the negedge where out_valid is seen
    task automatic wait_out(input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(input int max);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            step();
            if (exp_q.size() == 0 && dbg_state == ST_IDLE && bus.level == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", ok, 1);
    endtask

    // main sequence
    initial begin
        vec_t         vecs[8];
        int           s0;
        int           p0;
        int           z0;
        bit           ok;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{32,   16,   2,    1'b0};
        vecs[1] = '{110,  3,    36,   1'b0};
        vecs[2] = '{1023, 1,    1023, 1'b0};
        vecs[3] = '{0,    7,    0,    1'b0};
        vecs[4] = '{1000, 999,  1,    1'b0};
        vecs[5] = '{5,    0,    1023, 1'b1};
        vecs[6] = '{7,    9,    0,    1'b0};
        vecs[7] = '{1023, 1023, 1,    1'b0};

        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        rst          = 1'b0;

        // reset values while reset is held
        step();
        step();
        @(negedge clk);
        check("rst_div_start", bus.div_start, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_ov",    bus.out_ov, 0);
        check("rst_out_q",     bus.out_q, 0);
        check("rst_div_a",     bus.div_a, 0);
        check("rst_div_b",     bus.div_b, 0);
        check("rst_level",     bus.level, 0);
        check("rst_state",     dbg_state, ST_IDLE);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        step();

        // first pair: issue latency, single start pulse, single out_valid cycle
        s0 = start_cnt;
        bus.in_a     = 32;
        bus.in_b     = 16;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", bus.in_ready, 1);
        check("lat_no_start0", bus.div_start, 0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_level1", bus.level, 1);
        check("lat_no_start1", bus.div_start, 0);
        step();
        @(negedge clk);
        check("lat_start", bus.div_start, 1);
        check("lat_div_a", bus.div_a, 32);
        check("lat_div_b", bus.div_b, 16);
        check("lat_level0", bus.level, 0);
        step();
        @(negedge clk);
        check("lat_start_one_cycle", bus.div_start, 0);
        wait_out(20, ok);
        check("lat_out_seen", ok, 1);
        check("lat_out_q", bus.out_q, 2);
        check("lat_out_ov", bus.out_ov, 0);
        step();
        @(negedge clk);
        check("lat_out_one_cycle", bus.out_valid, 0);
        step();
        check("lat_start_count", start_cnt - s0, 1);

        // vector table
        for (int i = 0; i < 8; i++) begin
            s0 = start_cnt;
            offer(vecs[i].a, vecs[i].b);
            wait_out(50, ok);
            check($sformatf("vec%0d_out_seen", i), ok, 1);
            check($sformatf("vec%0d_q", i), bus.out_q, vecs[i].q);
            check($sformatf("vec%0d_ov", i), bus.out_ov, vecs[i].ov);
            step();
            check($sformatf("vec%0d_starts", i), start_cnt - s0,
                  (BYPASS && vecs[i].b == '0) ? 0 : 1);
        end
        drain(50);

        // full FIFO with the divider held busy
        force_busy = 1'b1;
        step();
        offer(100, 10);
        offer(200, 7);
        offer(999, 33);
        offer(50, 50);
        bus.in_a     = 1023;
        bus.in_b     = 2;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_level", bus.level, D);
            check("full_in_ready", bus.in_ready, 0);
            check("full_state_idle", dbg_state, ST_IDLE);
            step();
        end
        force_busy = 1'b0;
        @(negedge clk);
        check("full_still_blocked", bus.in_ready, 0);
        step();
        @(negedge clk);
        check("pop_in_ready", bus.in_ready, 1);
        check("pop_level", bus.level, D - 1);
        check("pop_start", bus.div_start, 1);
        check("pop_div_a", bus.div_a, 100);
        check("pop_div_b", bus.div_b, 10);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("refill_level", bus.level, D);
        step();
        drain(400);

        // result held while the sink stalls
        rdy_val = 1'b0;
        offer(500, 5);
        offer(77, 7);
        wait_out(60, ok);
        check("stall_out_seen", ok, 1);
        check("stall_out_q", bus.out_q, 100);
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_q_stable", bus.out_q, 100);
            check("stall_out_ov", bus.out_ov, 0);
            check("stall_no_start", bus.div_start, 0);
            check("stall_level", bus.level, 1);
        end
        step();
        rdy_val = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.div_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_next_issue", ok, 1);
        check("stall_next_div_a", bus.div_a, 77);
        step();
        drain(100);

        // reset while waiting on the divider, then a stray div_valid
        hang = 1'b1;
        offer(300, 3);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.div_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("wrst_issue", ok, 1);
        step();
        @(negedge clk);
        check("wrst_in_wait", dbg_state, ST_WAIT);
        step();
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        check("wrst_out_valid", bus.out_valid, 0);
        check("wrst_out_q", bus.out_q, 0);
        check("wrst_out_ov", bus.out_ov, 0);
        check("wrst_div_a", bus.div_a, 0);
        check("wrst_div_b", bus.div_b, 0);
        check("wrst_div_start", bus.div_start, 0);
        step();
        rst      = 1'b1;
        hang     = 1'b0;
        stray_on = 1'b1;
        step();
        stray_on = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stray_out_valid", bus.out_valid, 0);
            check("stray_level", bus.level, 0);
            check("stray_state", dbg_state, ST_IDLE);
            step();
        end

        // randomized traffic against the scoreboard
        rdy_mode = 1'b1;
        s0 = start_cnt;
        p0 = push_cnt;
        z0 = nz_push;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) step();
            ra = W'($urandom_range(0, 1023));
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom_range(1, 1023));
            endcase
            offer(ra, rb);
        end
        drain(2000);
        rdy_mode = 1'b0;
        check("rand_pushes", push_cnt - p0, 60);
        check("rand_starts", start_cnt - s0, BYPASS ? (nz_push - z0) : (push_cnt - p0));
        @(negedge clk);
        check("end_level", bus.level, 0);
        check("end_in_ready", bus.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 Parameter WIDTH, default 10, SHALL set the operand and quotient width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the operand FIFO depth in entries; it must be a power of two, 2 or more.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that an operand pair is offered.
REQ-006 in_ready  output  1  SHALL indicate that the FIFO can accept a pair.
REQ-007 in_a / in_b  input  WIDTH each  SHALL carry the dividend and the divisor.
REQ-008 div_start  output  1  SHALL be the one-cycle start pulse to the downstream divider.
REQ-009 div_a / div_b  output  WIDTH each  SHALL carry the operands presented to the divider.
REQ-010 div_busy / div_valid  input  1 each  SHALL carry the divider status and result-valid signals.
REQ-011 div_q  input  WIDTH  SHALL carry the divider quotient; div_ov  input  1  SHALL carry the divider overflow flag.
REQ-012 out_valid  output  1 / out_ready  input  1  SHALL form the result handshake.
REQ-013 out_q  output  WIDTH / out_ov  output  1  SHALL carry the delivered quotient and overflow flag.
REQ-014 level  output  clog2(DEPTH+1)  SHALL report the current FIFO occupancy.

Function
REQ-015 A pair SHALL be pushed into the FIFO on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be driven as not-full.
REQ-016 When the FIFO is full, in_ready SHALL be 0, so an offer made while full is not accepted, even if a pop occurs in the same cycle.
REQ-017 The read and write pointers SHALL wrap modulo DEPTH, and level SHALL count 0..DEPTH with no wrap.
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and HOLD.
REQ-019 In IDLE, when the FIFO is non-empty and div_busy is 0, the FSM SHALL pop the head pair into div_a/div_b and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 div_start SHALL be 1 only while the FSM is in ISSUE, for exactly one cycle; ISSUE SHALL then move to WAIT.
REQ-021 div_a and div_b SHALL be held stable from ISSUE through the end of WAIT.
REQ-022 In WAIT, when div_valid is 1, the block SHALL capture div_q into out_q and div_ov into out_ov, then move to HOLD.
REQ-023 div_valid SHALL be ignored in every state other than WAIT.
REQ-024 In HOLD, out_valid SHALL be 1 and out_q/out_ov SHALL be stable.
REQ-025 HOLD SHALL move to IDLE on the edge where out_ready is 1; no new issue SHALL occur while out_valid is 1.
REQ-026 A pair pushed into an empty FIFO while the FSM is idle and div_busy is 0 SHALL produce div_start in the cycle following the first edge after acceptance.
REQ-027 A push and a pop in the same edge SHALL leave level unchanged.
REQ-028 A pop SHALL never occur when the FIFO is empty.

Reset
REQ-029 When rst is 0 at a rising edge, the FSM SHALL go to IDLE and the FIFO SHALL be emptied (pointers 0, level 0).
REQ-030 During reset, div_start, out_valid, out_ov, out_q, div_a and div_b SHALL all be 0, and in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-031 A reset that occurs in ISSUE, WAIT or HOLD SHALL discard the in-flight pair; a later div_valid for that pair SHALL be ignored.

Configuration
REQ-032 Macro DIV_ZERO_BYPASS_EN SHALL control divide-by-zero handling.
REQ-033 With DIV_ZERO_BYPASS_EN defined, when IDLE pops a pair with divisor 0, the block SHALL skip ISSUE and WAIT: no div_start, out_q all ones, out_ov 1, and the FSM enters HOLD on the next edge.
REQ-034 With DIV_ZERO_BYPASS_EN undefined, a divisor-0 pair SHALL be issued to the divider like any other pair, and div_q/div_ov SHALL be forwarded unchanged.

Verification
REQ-035 Push a=32, b=16 with out_ready held at 1 -> exactly one div_start pulse; after the divider reports, out_valid is 1 for one cycle with out_q=2 and out_ov=0.
REQ-036 Push a=110, b=3 -> out_q=36 and out_ov=0; div_a=110 and div_b=3 are stable from ISSUE to div_valid.
REQ-037 Push 5 pairs back-to-back with div_busy held at 1 -> level reaches 4 and in_ready=0; the 5th pair is accepted only after the first pop; results emerge in push order.
REQ-038 Hold out_ready at 0 for 10 cycles in HOLD -> out_valid stays 1, out_q is stable, no div_start occurs; release out_ready -> the next pair issues.
REQ-039 Push a=5, b=0 -> with the macro defined: no div_start, out_q=1023 and out_ov=1; with the macro undefined: div_start occurs and the divider outputs are forwarded.
REQ-040 Assert reset while in WAIT, then pulse div_valid -> out_valid stays 0, level=0 and the FSM is in IDLE.
